// File: rtl/alu_if.sv
// Operand/result bundle between the datapath registers and the multi-cycle ALU.
// The master issues operations; the slave (the ALU) returns results and status.
interface alu_if #(parameter int WIDTH = 8);
    logic               op_begin;
    logic [1:0]         op;
    logic               sgn;
    logic [WIDTH-1:0]   ina;
    logic [WIDTH-1:0]   inm;
    logic               op_end;
    logic               busy;
    logic               ovf;
    logic               div0;
    logic [2*WIDTH-1:0] outbus;

    modport master (output op_begin, op, sgn, ina, inm,
                    input  op_end, busy, ovf, div0, outbus);
    modport slave  (input  op_begin, op, sgn, ina, inm,
                    output op_end, busy, ovf, div0, outbus);
endinterface

// File: rtl/alu_param.sv
// WIDTH-parametrised multi-cycle ALU: single-cycle ADD/SUB, Booth radix-2 MUL,
// restoring DIV with a sign-fix cycle. One operation in flight at a time.
module alu_param #(parameter int WIDTH = 8) (
    input  logic  clk,
    input  logic  rst_n,
    alu_if.slave  bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [1:0] IDLE = 2'd0, EXEC = 2'd1, FIX = 2'd2, DONE = 2'd3;
    localparam logic [1:0] OP_ADD = 2'd0, OP_SUB = 2'd1, OP_MUL = 2'd2, OP_DIV = 2'd3;

    logic [1:0]         state, op;
    logic               sgn, a_neg, m_neg, q1, div0_pend, ovf_pend;
    logic [CW-1:0]      cnt;
    logic [WIDTH+1:0]   hi;      // MUL accumulator / DIV partial remainder
    logic [WIDTH-1:0]   lo;      // MUL multiplier / DIV dividend -> quotient
    logic [WIDTH-1:0]   m;
    logic               end_r, ovf_r, div0_r;
    logic [2*WIDTH-1:0] out_r;

    logic [WIDTH-1:0]   m_mag, mul_hi;
    logic [WIDTH+1:0]   m_ext, booth_sum, trial;
    logic [2*WIDTH-1:0] a2, m2, as_res;
    logic [WIDTH:0]     as_top;
    logic               as_ovf, in_neg_a, in_neg_m, in_div0;

    always_comb begin
        m_mag  = m_neg ? -m : m;
        m_ext  = sgn ? {{2{m[WIDTH-1]}}, m} : {2'b00, m};
        unique case ({lo[0], q1})
            2'b01:   booth_sum = hi + m_ext;
            2'b10:   booth_sum = hi - m_ext;
            default: booth_sum = hi;
        endcase
        trial  = {1'b0, hi[WIDTH-1:0], lo[WIDTH-1]} - {2'b00, m_mag};
        // The last Booth pair is {q[W], q[W-1]}: nonzero only for unsigned with A[W-1]=1
        mul_hi = hi[WIDTH-1:0] + ((!sgn && q1) ? m : '0);
        a2     = sgn ? {{WIDTH{lo[WIDTH-1]}}, lo} : {{WIDTH{1'b0}}, lo};
        m2     = sgn ? {{WIDTH{m[WIDTH-1]}}, m}   : {{WIDTH{1'b0}}, m};
        as_res = (op == OP_SUB) ? a2 - m2 : a2 + m2;
        as_top = as_res[2*WIDTH-1:WIDTH-1];
        as_ovf = sgn ? !((&as_top) || !(|as_top)) : |as_res[2*WIDTH-1:WIDTH];
        in_neg_a = bus.sgn & bus.ina[WIDTH-1];
        in_neg_m = bus.sgn & bus.inm[WIDTH-1];
        in_div0  = (bus.op == OP_DIV) && (bus.inm == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;  op <= OP_ADD;  sgn <= 1'b0;
            a_neg <= 1'b0;  m_neg <= 1'b0; q1 <= 1'b0;
            div0_pend <= 1'b0; ovf_pend <= 1'b0;
            cnt <= '0;  hi <= '0;  lo <= '0;  m <= '0;
            end_r <= 1'b0;  ovf_r <= 1'b0;  div0_r <= 1'b0;  out_r <= '0;
        end else begin
            end_r <= 1'b0;
            unique case (state)
                IDLE: if (bus.op_begin) begin
                    op        <= bus.op;
                    sgn       <= bus.sgn;
                    a_neg     <= in_neg_a;
                    m_neg     <= in_neg_m;
                    m         <= bus.inm;
                    hi        <= '0;
                    q1        <= 1'b0;
                    cnt       <= '0;
                    div0_pend <= in_div0;
                    ovf_pend  <= (bus.op == OP_DIV) && bus.sgn && (&bus.inm) &&
                                 (bus.ina == {1'b1, {(WIDTH-1){1'b0}}});
                    // DIV iterates on magnitudes; divide-by-zero echoes the raw dividend
                    lo        <= ((bus.op == OP_DIV) && !in_div0 && in_neg_a) ? -bus.ina : bus.ina;
                    state     <= (bus.op[1] == 1'b0 || in_div0) ? DONE : EXEC;
                end
                EXEC: begin
                    if (op == OP_MUL) begin
                        hi <= {booth_sum[WIDTH+1], booth_sum[WIDTH+1:1]};
                        lo <= {booth_sum[0], lo[WIDTH-1:1]};
                        q1 <= lo[0];
                    end else if (!trial[WIDTH+1]) begin
                        hi <= {1'b0, trial[WIDTH:0]};
                        lo <= {lo[WIDTH-2:0], 1'b1};
                    end else begin
                        hi <= {1'b0, hi[WIDTH-1:0], lo[WIDTH-1]};
                        lo <= {lo[WIDTH-2:0], 1'b0};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= (op == OP_MUL) ? DONE : FIX;
                end
                FIX: begin
                    if (a_neg ^ m_neg) lo <= -lo;
                    if (a_neg)         hi <= {2'b00, -hi[WIDTH-1:0]};
                    state <= DONE;
                end
                default: begin
                    end_r <= 1'b1;
                    state <= IDLE;
                    unique case (op)
                        OP_ADD, OP_SUB: begin
                            out_r <= as_res;  ovf_r <= as_ovf;  div0_r <= 1'b0;
                        end
                        OP_MUL: begin
                            out_r <= {mul_hi, lo};  ovf_r <= 1'b0;  div0_r <= 1'b0;
                        end
                        default: begin
                            out_r  <= div0_pend ? {lo, {WIDTH{1'b1}}} : {hi[WIDTH-1:0], lo};
                            ovf_r  <= ovf_pend & ~div0_pend;
                            div0_r <= div0_pend;
                        end
                    endcase
                end
            endcase
        end
    end

    assign bus.op_end = end_r;
    assign bus.busy   = (state != IDLE);
    assign bus.ovf    = ovf_r;
    assign bus.div0   = div0_r;
    assign bus.outbus = out_r;
endmodule
